// File: rtl/preg_freelist.sv
// Circular free list of physical registers for rename: hands out up to two pregs per cycle,
// reclaims up to two stale pregs per cycle at commit, and rewinds on misprediction recovery.
module preg_freelist #(
  parameter int PREG_SIZE = 64,
  parameter int LREG_NUM  = 32
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         alloc_req0,
  input  logic                         alloc_req1,
  output logic                         alloc_ready,
  output logic                         alloc_en0,
  output logic [$clog2(PREG_SIZE)-1:0] alloc_addr0,
  output logic                         alloc_en1,
  output logic [$clog2(PREG_SIZE)-1:0] alloc_addr1,
  input  logic                         commit_free_en0,
  input  logic [$clog2(PREG_SIZE)-1:0] commit_free_addr0,
  input  logic                         commit_free_en1,
  input  logic [$clog2(PREG_SIZE)-1:0] commit_free_addr1,
  input  logic [1:0]                   rob_state,
  input  logic                         rob_walk0_valid,
  input  logic [$clog2(PREG_SIZE)-1:0] rob_walk0_prd,
  input  logic                         rob_walk1_valid,
  input  logic [$clog2(PREG_SIZE)-1:0] rob_walk1_prd,
  output logic [$clog2(PREG_SIZE-LREG_NUM):0] free_count
);

  localparam int PW       = $clog2(PREG_SIZE);
  localparam int FL_DEPTH = PREG_SIZE - LREG_NUM;
  localparam int IW       = $clog2(FL_DEPTH);
  localparam int PTRW     = IW + 1;

  localparam logic [1:0] ROB_STATE_IDLE          = 2'd0;
  localparam logic [1:0] ROB_STATE_WALKING       = 2'd1;
  localparam logic [1:0] ROB_STATE_OVERWRITE_RAT = 2'd2;

  logic [PW-1:0]   mem_reg [FL_DEPTH];
  logic [PTRW-1:0] head_reg, head_next;
  logic [PTRW-1:0] tail_reg, tail_next;
  logic [PTRW-1:0] arch_head_reg, arch_head_next;

  logic            is_idle;
  logic [IW-1:0]   head_idx, head_idx1, tail_idx, tail_idx1;
  logic [PTRW-1:0] alloc_cnt, free_cnt, walk_cnt, spec_cnt;
  logic            wr0_en, wr1_en;
  logic [PW-1:0]   wr0_data;

  assign is_idle     = (rob_state == ROB_STATE_IDLE);
  assign free_count  = tail_reg - head_reg;
  // Readiness looks only at the registered count; same-cycle frees are not bypassed.
  assign alloc_ready = is_idle && (free_count >= PTRW'(2));
  assign alloc_en0   = alloc_req0 & alloc_ready;
  assign alloc_en1   = alloc_req1 & alloc_ready;

  assign head_idx    = head_reg[IW-1:0];
  assign head_idx1   = head_idx + IW'(1);
  assign tail_idx    = tail_reg[IW-1:0];
  assign tail_idx1   = tail_idx + IW'(1);

  // A lone slot-1 request takes the head entry so the list stays compact.
  assign alloc_addr0 = mem_reg[head_idx];
  assign alloc_addr1 = (alloc_en1 && !alloc_en0) ? mem_reg[head_idx] : mem_reg[head_idx1];

  assign alloc_cnt = PTRW'(alloc_en0) + PTRW'(alloc_en1);
  assign free_cnt  = PTRW'(commit_free_en0) + PTRW'(commit_free_en1);
  assign walk_cnt  = PTRW'(rob_walk0_valid) + PTRW'(rob_walk1_valid);
  assign spec_cnt  = head_reg - arch_head_reg;

  assign wr0_en   = commit_free_en0 | commit_free_en1;
  assign wr1_en   = commit_free_en0 & commit_free_en1;
  assign wr0_data = commit_free_en0 ? commit_free_addr0 : commit_free_addr1;

  always_comb begin
    head_next = head_reg;
    case (rob_state)
      ROB_STATE_IDLE:          head_next = head_reg + alloc_cnt;
      ROB_STATE_WALKING:       head_next = head_reg - walk_cnt;
      ROB_STATE_OVERWRITE_RAT: head_next = arch_head_reg;
      default:                 head_next = head_reg;
    endcase
  end

  assign tail_next      = tail_reg + free_cnt;
  assign arch_head_next = arch_head_reg + free_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_reg      <= '0;
      tail_reg      <= {1'b1, {IW{1'b0}}};
      arch_head_reg <= '0;
    end else begin
      head_reg      <= head_next;
      tail_reg      <= tail_next;
      arch_head_reg <= arch_head_next;
    end
  end

  // Storage resets to the non-architectural pregs, so it lives in flops rather than RAM.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FL_DEPTH; i++) mem_reg[i] <= PW'(LREG_NUM + i);
    end else begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        if (wr0_en && (tail_idx == IW'(i)))
          mem_reg[i] <= wr0_data;
        else if (wr1_en && (tail_idx1 == IW'(i)))
          mem_reg[i] <= commit_free_addr1;
      end
    end
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    wr0_en |-> (free_count != PTRW'(FL_DEPTH)));

  a_walk_not_past_arch: assert property (@(posedge clock) disable iff (!reset_n)
    (rob_state == ROB_STATE_WALKING) |-> (spec_cnt >= walk_cnt));

  a_walk0_prd: assert property (@(posedge clock) disable iff (!reset_n)
    (rob_state == ROB_STATE_WALKING && rob_walk0_valid)
      |-> (rob_walk0_prd == mem_reg[head_idx - IW'(1)]));

  a_walk1_prd: assert property (@(posedge clock) disable iff (!reset_n)
    (rob_state == ROB_STATE_WALKING && rob_walk0_valid && rob_walk1_valid)
      |-> (rob_walk1_prd == mem_reg[head_idx - IW'(2)]));

endmodule
